// File: rtl/hp_controller_if.sv
// -----------------------------------------------------------------------------
// hp_controller_if
// Purpose : Groups the request and status signals between the game logic and
//           the player heart controller, so one bundle carries the whole link.
// Signals :
//   frame_tick  one-Clk pulse per video frame (vsync derived)
//   start       begins or restarts a game
//   hit         one-Clk damage request
//   heal        one-Clk +1 hp request
//   hp          current hp (0..3) for the heart renderer
//   HP_exist    heart display enable, blinks while invulnerable
//   invincible  high during the post-hit invulnerability window
//   game_over   high once the death sequence has completed
// Modports:
//   slave   controller side (consumes requests, produces status)
//   master  game-logic / stimulus side
// -----------------------------------------------------------------------------
interface hp_controller_if;
  logic       frame_tick;
  logic       start;
  logic       hit;
  logic       heal;
  logic [1:0] hp;
  logic       HP_exist;
  logic       invincible;
  logic       game_over;

  modport slave (
    input  frame_tick,
    input  start,
    input  hit,
    input  heal,
    output hp,
    output HP_exist,
    output invincible,
    output game_over
  );

  modport master (
    output frame_tick,
    output start,
    output hit,
    output heal,
    input  hp,
    input  HP_exist,
    input  invincible,
    input  game_over
  );
endinterface

// File: rtl/hp_controller.sv
// -----------------------------------------------------------------------------
// hp_controller
// Purpose : Owns the player's hp count. Applies damage and heal requests,
//           runs the invulnerability window after a non-fatal hit (with the
//           heart display blinking), and the timed death / game-over sequence.
// Ports   :
//   Clk    system clock, all state changes on the rising edge
//   Reset  synchronous, active-low reset
//   bus    hp_controller_if.slave
//            in : frame_tick, start, hit, heal
//            out: hp[1:0], HP_exist, invincible, game_over (all registered)
// Parameters:
//   MAX_HP         starting and maximum hp (1..3)
//   INVULN_FRAMES  frames of invulnerability after a non-fatal hit (1..255)
//   BLINK_PERIOD   frames between HP_exist toggles while invulnerable (1..255)
//   DEATH_FRAMES   frames from the fatal hit to game_over (1..255)
// -----------------------------------------------------------------------------
module hp_controller #(
  parameter int unsigned MAX_HP        = 3,
  parameter int unsigned INVULN_FRAMES = 60,
  parameter int unsigned BLINK_PERIOD  = 8,
  parameter int unsigned DEATH_FRAMES  = 120
) (
  input  logic              Clk,
  input  logic              Reset,
  hp_controller_if.slave    bus
);

  localparam logic [1:0] LP_MAX_HP    = 2'(MAX_HP);
  localparam logic [7:0] LP_INVULN    = 8'(INVULN_FRAMES);
  localparam logic [7:0] LP_BLINK     = 8'(BLINK_PERIOD);
  localparam logic [7:0] LP_DEATH     = 8'(DEATH_FRAMES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ALIVE  = 3'd1,
    S_INVULN = 3'd2,
    S_DYING  = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  state_t     r_state;
  logic [1:0] r_hp;
  logic       r_hp_exist;
  logic       r_invincible;
  logic       r_game_over;
  logic [7:0] r_frame_cnt;
  logic [7:0] r_blink_cnt;

  // Heal is saturating in every state that accepts it.
  logic       w_can_heal;
  logic [7:0] w_blink_inc;

  assign w_can_heal  = bus.heal && (r_hp < LP_MAX_HP);
  assign w_blink_inc = r_blink_cnt + 8'd1;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_hp         <= 2'd0;
      r_hp_exist   <= 1'b0;
      r_invincible <= 1'b0;
      r_game_over  <= 1'b0;
      r_frame_cnt  <= 8'd0;
      r_blink_cnt  <= 8'd0;
    end else begin
      case (r_state)
        // Waiting for the first game; damage, heal and frame ticks do nothing.
        S_IDLE: begin
          if (bus.start) begin
            r_state      <= S_ALIVE;
            r_hp         <= LP_MAX_HP;
            r_hp_exist   <= 1'b1;
            r_invincible <= 1'b0;
            r_game_over  <= 1'b0;
          end
        end

        // Normal play. A hit takes priority over a heal and over a coincident
        // frame tick: the window counter loads its full value and that tick
        // is not counted.
        S_ALIVE: begin
          if (bus.hit) begin
            if (r_hp > 2'd1) begin
              r_state      <= S_INVULN;
              r_hp         <= r_hp - 2'd1;
              r_frame_cnt  <= LP_INVULN;
              r_blink_cnt  <= 8'd0;
              r_hp_exist   <= 1'b1;
              r_invincible <= 1'b1;
            end else begin
              r_state      <= S_DYING;
              r_hp         <= 2'd0;
              r_frame_cnt  <= LP_DEATH;
              r_hp_exist   <= 1'b0;
              r_invincible <= 1'b0;
            end
          end else if (w_can_heal) begin
            r_hp <= r_hp + 2'd1;
          end
        end

        // Invulnerable: hits are ignored, heals still land. The heal is
        // independent of the tick, so an expiring tick and a heal both apply.
        S_INVULN: begin
          if (w_can_heal) begin
            r_hp <= r_hp + 2'd1;
          end
          if (bus.frame_tick) begin
            if (r_frame_cnt == 8'd1) begin
              // Leave with the heart solidly shown; blink phase is discarded.
              r_state      <= S_ALIVE;
              r_frame_cnt  <= 8'd0;
              r_blink_cnt  <= 8'd0;
              r_hp_exist   <= 1'b1;
              r_invincible <= 1'b0;
            end else begin
              r_frame_cnt <= r_frame_cnt - 8'd1;
              if (w_blink_inc == LP_BLINK) begin
                r_blink_cnt <= 8'd0;
                r_hp_exist  <= ~r_hp_exist;
              end else begin
                r_blink_cnt <= w_blink_inc;
              end
            end
          end
        end

        // Death animation time: everything but the frame tick is ignored.
        S_DYING: begin
          r_hp       <= 2'd0;
          r_hp_exist <= 1'b0;
          if (bus.frame_tick) begin
            if (r_frame_cnt == 8'd1) begin
              r_state     <= S_OVER;
              r_frame_cnt <= 8'd0;
              r_game_over <= 1'b1;
            end else begin
              r_frame_cnt <= r_frame_cnt - 8'd1;
            end
          end
        end

        // Game over until a new start.
        S_OVER: begin
          r_hp        <= 2'd0;
          r_hp_exist  <= 1'b0;
          r_game_over <= 1'b1;
          if (bus.start) begin
            r_state      <= S_ALIVE;
            r_hp         <= LP_MAX_HP;
            r_hp_exist   <= 1'b1;
            r_invincible <= 1'b0;
            r_game_over  <= 1'b0;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_hp         <= 2'd0;
          r_hp_exist   <= 1'b0;
          r_invincible <= 1'b0;
          r_game_over  <= 1'b0;
          r_frame_cnt  <= 8'd0;
          r_blink_cnt  <= 8'd0;
        end
      endcase
    end
  end

  assign bus.hp         = r_hp;
  assign bus.HP_exist   = r_hp_exist;
  assign bus.invincible = r_invincible;
  assign bus.game_over  = r_game_over;

endmodule

// File: tb/tb_hp_controller.sv
// -----------------------------------------------------------------------------
// tb_hp_controller
// Purpose : Self-checking bench for hp_controller. Stimulus drives one cycle
//           at a time and pushes the hand-computed expected outputs for that
//           cycle into a scoreboard queue; a separate monitor pops and
//           compares after each rising edge.
// -----------------------------------------------------------------------------
module tb_hp_controller;

  localparam int MAX_HP = 3;
  localparam int INV    = 60;
  localparam int BLINK  = 8;
  localparam int DEATH  = 120;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  hp_controller_if bus ();

  hp_controller #(
    .MAX_HP       (MAX_HP),
    .INVULN_FRAMES(INV),
    .BLINK_PERIOD (BLINK),
    .DEATH_FRAMES (DEATH)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int         cyc;
    string      name;
    logic [1:0] hp;
    logic       ex;
    logic       inv;
    logic       go;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: every cycle the outputs are presented; compare any expectation
  // that was queued for this edge.
  always @(posedge Clk) begin : monitor
    exp_t x;
    #1;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      x = sb_q.pop_front();
      checks++;
      if ({bus.hp, bus.HP_exist, bus.invincible, bus.game_over} !==
          {x.hp, x.ex, x.inv, x.go}) begin
        failures++;
        $display("FAIL %s: got hp=%0d exist=%b inv=%b over=%b, expected hp=%0d exist=%b inv=%b over=%b",
                 x.name, bus.hp, bus.HP_exist, bus.invincible, bus.game_over,
                 x.hp, x.ex, x.inv, x.go);
      end else begin
        $display("check %s: hp=%0d exist=%b inv=%b over=%b ok",
                 x.name, bus.hp, bus.HP_exist, bus.invincible, bus.game_over);
      end
    end
  end

  task automatic drive(input logic rst, input logic ft, input logic st,
                       input logic hi, input logic he);
    @(negedge Clk);
    Reset          = rst;
    bus.frame_tick = ft;
    bus.start      = st;
    bus.hit        = hi;
    bus.heal       = he;
  endtask

  task automatic expect_out(input string nm, input logic [1:0] h,
                            input logic e, input logic i, input logic g);
    exp_t x;
    x.cyc  = cyc + 1;
    x.name = nm;
    x.hp   = h;
    x.ex   = e;
    x.inv  = i;
    x.go   = g;
    sb_q.push_back(x);
  endtask

  // Full invulnerability window of INV ticks at hp h. HP_exist toggles every
  // BLINK ticks; the last tick returns to ALIVE with the heart shown. With
  // heal_last the final tick also carries a heal.
  task automatic invuln_run(input string nm, input logic [1:0] h,
                            input logic hits, input logic heal_last);
    for (int t = 1; t <= INV; t++) begin
      drive(1'b1, 1'b1, 1'b0, hits, heal_last && (t == INV));
      if (t < INV)
        expect_out($sformatf("%s_t%0d", nm, t), h, ((t / BLINK) % 2) == 0, 1'b1, 1'b0);
      else
        expect_out($sformatf("%s_end", nm), heal_last ? h + 2'd1 : h, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.hit        = 1'b0;
    bus.heal       = 1'b0;

    // Reset held for two cycles, overriding other inputs.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("reset0", 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1); expect_out("reset_overrides", 2'd0, 1'b0, 1'b0, 1'b0);

    // Start the game.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("start", 2'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); expect_out("heal_at_max", 2'd3, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("start_in_alive", 2'd3, 1'b1, 1'b0, 1'b0);

    // First hit, then hits are ignored through the whole window.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); expect_out("hit1", 2'd2, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0); expect_out("hit_ignored", 2'd2, 1'b1, 1'b1, 1'b0);
    invuln_run("inv_a", 2'd2, 1'b1, 1'b0);

    // Hit and heal together at hp=2: hit wins.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); expect_out("hit_heal", 2'd1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("heal_invuln", 2'd2, 1'b1, 1'b1, 1'b0);
    // Window expiry coincident with a heal: exit and hp+1.
    invuln_run("inv_b", 2'd2, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); expect_out("heal_sat", 2'd3, 1'b1, 1'b0, 1'b0);

    // Hit coincident with a frame tick: that tick is not counted.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0); expect_out("hit_tick", 2'd2, 1'b1, 1'b1, 1'b0);
    invuln_run("inv_c", 2'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); expect_out("hit_to_1", 2'd1, 1'b1, 1'b1, 1'b0);
    invuln_run("inv_d", 2'd1, 1'b0, 1'b0);

    // Fatal hit (with coincident tick and heal), then the death timer.
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1); expect_out("fatal_hit", 2'd0, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= DEATH; t++) begin
      drive(1'b1, 1'b1, t == 50, t == 70, t == 90);
      expect_out($sformatf("dying_t%0d", t), 2'd0, 1'b0, 1'b0, (t == DEATH));
    end
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1); expect_out("over_hold", 2'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("restart", 2'd3, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of an invulnerability window.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); expect_out("hit_r", 2'd2, 1'b1, 1'b1, 1'b0);
    for (int t = 1; t <= 30; t++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_out($sformatf("inv_r_t%0d", t), 2'd2, ((t / BLINK) % 2) == 0, 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); expect_out("reset_mid_invuln", 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); expect_out("idle_hit", 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); expect_out("idle_heal_tick", 2'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); expect_out("start_again", 2'd3, 1'b1, 1'b0, 1'b0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge Clk);

    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hp_controller.md
Name: hp_controller

Overview:
- Sequences the player's heart display: owns the hp count, applies damage and heal requests, runs the post-hit invulnerability window with heart blinking, and the death/game-over sequence.
- Drives the hp and HP_exist inputs of the heart sprite renderer.
- Exports invincible and game_over to the game-state logic.
- Frame-based timing uses a one-cycle frame tick derived from vertical sync.

Parameters:
MAX_HP, 3, starting and maximum hp (1..3; hp is 2 bits)
INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit (1..255)
BLINK_PERIOD, 8, frames between HP_exist toggles while invulnerable (1..255)
DEATH_FRAMES, 120, frames between the fatal hit and game_over assertion (1..255)

Ports:
Clk  input  1  system clock; all state changes on posedge
Reset  input  1  synchronous, active-low reset
frame_tick  input  1  one-Clk pulse per video frame
start  input  1  level/pulse; begins or restarts a game
hit  input  1  one-Clk damage request
heal  input  1  one-Clk +1 hp request
hp  output  2  current hp to heart renderer
HP_exist  output  1  heart display enable (blinks during invulnerability)
invincible  output  1  high while in INVULN
game_over  output  1  high in OVER

Behaviour:
- All outputs are registered. Any input sampled at posedge N is reflected in the outputs after posedge N; there is no combinational input-to-output path.
- Reset (Reset==0 at posedge) overrides all other inputs:
  - state=IDLE, hp=0, HP_exist=0, invincible=0, game_over=0.
  - frame counter=0, blink counter=0.
  - Takes effect from any state, including mid-INVULN or mid-DYING.
- States: IDLE, ALIVE, INVULN, DYING, OVER.
- IDLE:
  - start=1 -> ALIVE, hp=MAX_HP, HP_exist=1.
  - hit, heal and frame_tick are ignored.
- ALIVE (HP_exist=1, invincible=0):
  - hit with hp>1 -> hp-1, enter INVULN. On entry: frame counter=INVULN_FRAMES, blink counter=0, HP_exist=1, invincible=1.
  - hit with hp==1 -> hp=0, enter DYING, frame counter=DEATH_FRAMES, HP_exist=0.
  - heal -> hp+1, saturating at MAX_HP (heal at MAX_HP is a no-op).
  - hit and heal in the same cycle: hit wins, heal is dropped.
- INVULN:
  - hit is ignored.
  - heal is applied as in ALIVE (saturating).
  - On each frame_tick:
    - frame counter decrements.
    - blink counter increments. When it reaches BLINK_PERIOD it resets to 0 and HP_exist toggles.
  - frame_tick with frame counter==1 -> ALIVE: counter=0, HP_exist=1, invincible=0.
  - Blink state is not carried into ALIVE.
- DYING:
  - hp=0, HP_exist=0.
  - hit and heal are ignored.
  - frame_tick decrements the counter. frame_tick with counter==1 -> OVER, game_over=1.
- OVER:
  - game_over=1, hp=0, HP_exist=0.
  - start=1 -> ALIVE with hp=MAX_HP, HP_exist=1, game_over=0.
- start is ignored in ALIVE, INVULN and DYING.
- frame_tick coincident with hit in ALIVE: the hit transition takes priority. The counter loads the full INVULN_FRAMES or DEATH_FRAMES; that tick is not counted.
- frame_tick coincident with the expiry of INVULN and a heal: both apply (exit to ALIVE, hp+1).
- Counters are 8 bits. Parameters outside their stated ranges are illegal and do not need to be checked in RTL.
- hp never underflows below 0 or exceeds MAX_HP.

Test Plan:
- Reset=0 for 2 cycles, then 1; pulse start -> next cycle hp=3, HP_exist=1, state ALIVE, invincible=0, game_over=0.
- Pulse hit in ALIVE -> hp=2, invincible=1. Further hit pulses over 60 frame_ticks leave hp=2. HP_exist toggles after frame_ticks 8, 16, 24, .... After the 60th tick: invincible=0, HP_exist=1.
- At hp=2 in ALIVE, assert hit and heal in the same cycle -> hp=1, INVULN entered. heal at hp=3 -> hp stays 3. heal during INVULN at hp=1 -> hp=2.
- hit at hp=1 -> hp=0, HP_exist=0. game_over stays 0 for 119 frame_ticks and rises on the 120th. start then gives hp=3, game_over=0.
- Reset=0 mid-INVULN (after 30 ticks) -> next cycle hp=0, HP_exist=0, invincible=0, IDLE. A hit pulse in IDLE leaves hp=0.
- start pulses in ALIVE and DYING -> no change to hp or state.
